cfeb_link_mon: RTL and testbench
================================

Name: cfeb_link_mon

Overview:
- Per-fiber link monitor for one DCFEB optical link, one instance per CFEB.
- Sits between the GTX receiver/8b10b decoder and the chamber-level sync monitor.
- Qualifies each received frame-separator K-char and runs a link-up state machine.
- Tracks the periodic FC50 marker and produces the per-CFEB status the sync monitor consumes: kchar, link_good, lt_trg_err and sync_done.

Parameters:
GOOD_CNT, 8, consecutive good frames required in ACQUIRE before link declared up (2..255)
BAD_CNT, 4, bad frames within one window that drop the link (1..255)
WIN_LEN, 64, error window length in clocks (2..65535)
MARKER_PERIOD, 128, clocks between FC markers at 40 MHz (2..256)

Ports:
clock  in  1  40 MHz LHC clock, all logic on rising edge
global_reset_n  in  1  asynchronous active-low reset
rx_kchar  in  8  decoded frame-separator K-char this clock
rx_kchar_valid  in  1  decoder byte-aligned, K-char slot valid
rx_code_err  in  1  disparity or not-in-table error this clock
fiber_enable  in  1  fiber enabled by configuration
ttc_resync  in  1  TTC resync, level, synchronous to clock
err_cnt_clr  in  1  clear error counter
kchar  out  8  registered rx_kchar
link_good  out  1  link state UP
lt_trg_err  out  1  one-clock pulse on marker-phase error
sync_done  out  1  marker phase established since last resync
err_cnt  out  16  saturating error count

Behaviour:
- Reset (async, global_reset_n=0): kchar=8'h00; link_good=0; lt_trg_err=0; sync_done=0; err_cnt=0; FSM=DOWN; all internal counters 0; marker_locked=0.
- good frame = rx_kchar_valid & ~rx_code_err & (rx_kchar==8'hBC | rx_kchar==8'hFC). bad frame = not good.
- fc = good frame & rx_kchar==8'hFC.
- kchar output: rx_kchar registered every clock, 1-clock latency, independent of FSM.
- FSM states: DOWN=0, ACQUIRE=1, UP=2.
- fiber_enable=0 forces DOWN from any state on the next edge; this has priority over all other transitions.
- DOWN: a good frame moves to ACQUIRE with good_cnt=1.
- ACQUIRE:
  - good frame increments good_cnt.
  - The good frame that brings good_cnt to GOOD_CNT moves to UP; link_good=1 on that same edge.
  - Any bad frame moves to DOWN and sets good_cnt=0.
- UP, window and bad-frame counting:
  - win_cnt counts 0..WIN_LEN-1 and wraps. It restarts at 0 on UP entry.
  - bad_cnt clears at each wrap. If a bad frame coincides with the wrap, bad_cnt=1 (the bad frame is counted in the new window).
  - When a bad frame brings bad_cnt to BAD_CNT, go to DOWN; link_good=0 on that edge.
- link_good = (state==UP), registered.
- Marker tracking, active only in UP:
  - First fc after UP entry: phase=0, marker_locked=1.
  - Then phase increments each clock and wraps at MARKER_PERIOD-1 -> 0. Any fc reloads phase=0 (realign).
- lt_trg_err: registered one-clock pulse when marker_locked=1 and either
  - fc arrives while phase != MARKER_PERIOD-1, or
  - phase == MARKER_PERIOD-1 and no fc arrives.
- sync_done:
  - Forced 1 while fiber_enable=0, so a disabled fiber never blocks the chamber AND.
  - Otherwise set on the edge that sets marker_locked.
  - Cleared, together with marker_locked, by ttc_resync=1 or any exit from UP.
  - ttc_resync takes priority over a simultaneous first fc. Marker search restarts on the first fc after ttc_resync deasserts.
- err_cnt: 16-bit saturating at 16'hFFFF.
  - +1 per bad frame while UP; +1 per lt_trg_err pulse; +2 if both occur in the same clock.
  - Cleared by err_cnt_clr or ttc_resync; clear wins over increment.
- The FSM holds its state through ttc_resync; resync does not drop the link.

Optional Feature:
- Macro: CFEB_LINK_MON_ERR_CNT_EN.
- Defined: err_cnt implemented as specified.
- Undefined: counter logic omitted and err_cnt tied to 16'h0000. All other outputs are identical in both builds.

Test Plan:
- Reset release, fiber_enable=1, continuous valid 8'hBC -> ACQUIRE after 1 clock, link_good=1 after GOOD_CNT=8 good frames, sync_done stays 0, kchar tracks input with 1-clock delay.
- Link UP, FC injected every 128 clocks -> sync_done=1 on the edge after the first FC, no lt_trg_err over 10 periods, err_cnt=0.
- Locked, one FC delivered at phase 100 -> lt_trg_err pulse exactly 1 clock, phase realigns, next FC 128 clocks later gives no error, err_cnt=1.
- UP, 3 rx_code_err in one 64-clock window -> stays UP. 4 errors in one window -> link_good=0, sync_done=0. 3 errors spanning the window wrap (2+1) -> stays UP.
- ttc_resync pulse while locked and err_cnt=5 -> sync_done=0, err_cnt=0, link_good stays 1, sync_done=1 again on next FC.
- fiber_enable=0 mid-UP -> link_good=0 next clock, sync_done=1. global_reset_n asserted mid-ACQUIRE -> all outputs 0 immediately.

Source files
------------

// File: rtl/cfeb_link_mon_if.sv
// Per-CFEB link bus: decoder-side inputs, configuration/TTC controls and status outputs.
// The monitor takes the slave view; the driver of the link (decoder model / bench) takes master.
interface cfeb_link_mon_if;
  logic [7:0]  rx_kchar;
  logic        rx_kchar_valid;
  logic        rx_code_err;
  logic        fiber_enable;
  logic        ttc_resync;
  logic        err_cnt_clr;
  logic [7:0]  kchar;
  logic        link_good;
  logic        lt_trg_err;
  logic        sync_done;
  logic [15:0] err_cnt;

  modport master (
    output rx_kchar, rx_kchar_valid, rx_code_err, fiber_enable, ttc_resync, err_cnt_clr,
    input  kchar, link_good, lt_trg_err, sync_done, err_cnt
  );

  modport slave (
    input  rx_kchar, rx_kchar_valid, rx_code_err, fiber_enable, ttc_resync, err_cnt_clr,
    output kchar, link_good, lt_trg_err, sync_done, err_cnt
  );
endinterface

// File: rtl/cfeb_link_mon.sv
// DCFEB fiber monitor: frame qualification, DOWN/ACQUIRE/UP link FSM, FC50 marker phase check.
// Latency: all status outputs registered, 1 clock; no backpressure, one K-char slot per clock.
// CFEB_LINK_MON_ERR_CNT_EN enables the saturating error counter; otherwise err_cnt reads 0.
module cfeb_link_mon #(
  parameter int GOOD_CNT      = 8,
  parameter int BAD_CNT       = 4,
  parameter int WIN_LEN       = 64,
  parameter int MARKER_PERIOD = 128
) (
  input  logic            clock,
  input  logic            global_reset_n,
  cfeb_link_mon_if.slave  bus
);

  typedef enum logic [1:0] {DOWN = 2'd0, ACQUIRE = 2'd1, UP = 2'd2} state_t;

  localparam logic [7:0]  GOOD_LAST = 8'(GOOD_CNT);
  localparam logic [7:0]  BAD_LAST  = 8'(BAD_CNT);
  localparam logic [15:0] WIN_LAST  = 16'(WIN_LEN - 1);
  localparam logic [7:0]  PH_LAST   = 8'(MARKER_PERIOD - 1);

  state_t      state_q, state_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [7:0]  bad_cnt_q, bad_cnt_d;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic [7:0]  phase_q, phase_d;
  logic        marker_locked_q, marker_locked_d;
  logic        link_good_q, link_good_d;
  logic        lt_trg_err_q, lt_trg_err_d;
  logic        sync_done_q, sync_done_d;
  logic [7:0]  kchar_q, kchar_d;

  logic        good, fc, in_up, win_wrap;
  logic [7:0]  bad_base;

  assign good  = bus.rx_kchar_valid & ~bus.rx_code_err &
                 ((bus.rx_kchar == 8'hBC) | (bus.rx_kchar == 8'hFC));
  assign fc    = good & (bus.rx_kchar == 8'hFC);
  assign in_up = (state_q == UP);

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    win_cnt_d  = win_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    win_wrap   = (win_cnt_q == WIN_LAST);
    bad_base   = win_wrap ? 8'd0 : bad_cnt_q;
    case (state_q)
      DOWN: begin
        if (good) begin
          state_d    = ACQUIRE;
          good_cnt_d = 8'd1;
        end
      end
      ACQUIRE: begin
        if (good) begin
          good_cnt_d = good_cnt_q + 8'd1;
          if (good_cnt_q + 8'd1 == GOOD_LAST) begin
            state_d    = UP;
            good_cnt_d = 8'd0;
            win_cnt_d  = 16'd0;
            bad_cnt_d  = 8'd0;
          end
        end else begin
          state_d    = DOWN;
          good_cnt_d = 8'd0;
        end
      end
      UP: begin
        // A bad frame on the wrap clock is the first one of the new window.
        win_cnt_d = win_wrap ? 16'd0 : win_cnt_q + 16'd1;
        bad_cnt_d = bad_base + {7'd0, ~good};
        if (~good && (bad_cnt_d == BAD_LAST)) begin
          state_d   = DOWN;
          win_cnt_d = 16'd0;
          bad_cnt_d = 8'd0;
        end
      end
      default: state_d = DOWN;
    endcase
    if (~bus.fiber_enable) begin
      state_d    = DOWN;
      good_cnt_d = 8'd0;
      win_cnt_d  = 16'd0;
      bad_cnt_d  = 8'd0;
    end
  end

  always_comb begin
    marker_locked_d = marker_locked_q;
    phase_d         = phase_q;
    lt_trg_err_d    = 1'b0;
    if (in_up) begin
      if (marker_locked_q) begin
        lt_trg_err_d = fc ? (phase_q != PH_LAST) : (phase_q == PH_LAST);
        phase_d      = (fc || (phase_q == PH_LAST)) ? 8'd0 : phase_q + 8'd1;
      end else if (fc) begin
        marker_locked_d = 1'b1;
        phase_d         = 8'd0;
      end
      // Resync beats a coincident first FC; search resumes once it drops.
      if (bus.ttc_resync) begin
        marker_locked_d = 1'b0;
        phase_d         = 8'd0;
        lt_trg_err_d    = 1'b0;
      end
    end
    if (state_d != UP) begin
      marker_locked_d = 1'b0;
      phase_d         = 8'd0;
    end
    sync_done_d = ~bus.fiber_enable | marker_locked_d;
    link_good_d = (state_d == UP);
    kchar_d     = bus.rx_kchar;
  end

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q         <= DOWN;
      good_cnt_q      <= 8'd0;
      bad_cnt_q       <= 8'd0;
      win_cnt_q       <= 16'd0;
      phase_q         <= 8'd0;
      marker_locked_q <= 1'b0;
      link_good_q     <= 1'b0;
      lt_trg_err_q    <= 1'b0;
      sync_done_q     <= 1'b0;
      kchar_q         <= 8'h00;
    end else begin
      state_q         <= state_d;
      good_cnt_q      <= good_cnt_d;
      bad_cnt_q       <= bad_cnt_d;
      win_cnt_q       <= win_cnt_d;
      phase_q         <= phase_d;
      marker_locked_q <= marker_locked_d;
      link_good_q     <= link_good_d;
      lt_trg_err_q    <= lt_trg_err_d;
      sync_done_q     <= sync_done_d;
      kchar_q         <= kchar_d;
    end
  end

  assign bus.kchar      = kchar_q;
  assign bus.link_good  = link_good_q;
  assign bus.lt_trg_err = lt_trg_err_q;
  assign bus.sync_done  = sync_done_q;

`ifdef CFEB_LINK_MON_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  always_comb begin
    err_inc   = {1'b0, in_up & ~good} + {1'b0, lt_trg_err_d};
    err_sum   = {1'b0, err_cnt_q} + {15'd0, err_inc};
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    if (bus.err_cnt_clr || bus.ttc_resync) err_cnt_d = 16'd0;
  end

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) err_cnt_q <= 16'd0;
    else                 err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`else
  logic unused_err_cnt_clr;
  assign unused_err_cnt_clr = bus.err_cnt_clr;
  assign bus.err_cnt        = 16'h0000;
`endif

endmodule

// File: tb/tb_cfeb_link_mon.sv
// Randomized bench for cfeb_link_mon against a cycle-count based reference model.
module tb_cfeb_link_mon;
  localparam int GOOD_CNT = 8;
  localparam int BAD_CNT  = 4;
  localparam int WIN_LEN  = 64;
  localparam int MP       = 128;

  logic clock;
  logic global_reset_n;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  cfeb_link_mon_if lnk();

  cfeb_link_mon #(
    .GOOD_CNT(GOOD_CNT), .BAD_CNT(BAD_CNT), .WIN_LEN(WIN_LEN), .MARKER_PERIOD(MP)
  ) u_dut (
    .clock          (clock),
    .global_reset_n (global_reset_n),
    .bus            (lnk)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: link up/down, window index from cycles since UP entry,
  // marker phase as distance from the last accepted FC.
  bit      m_up, m_locked;
  int      m_run, m_age, m_win, m_win_bad, m_cyc, m_last_fc, m_err;
  logic [7:0] e_kchar;
  bit      e_link, e_lt, e_sync;

  task automatic model_reset();
    m_up = 0; m_locked = 0; m_run = 0; m_age = 0; m_win = 0; m_win_bad = 0;
    m_cyc = 0; m_last_fc = 0; m_err = 0;
    e_kchar = 8'h00; e_link = 0; e_lt = 0; e_sync = 0;
  endtask

  task automatic model_step();
    bit good, fc, bad_up, up_n, lt_n;
    int d;
    int w;
    good = lnk.rx_kchar_valid && !lnk.rx_code_err &&
           (lnk.rx_kchar == 8'hBC || lnk.rx_kchar == 8'hFC);
    fc   = good && (lnk.rx_kchar == 8'hFC);
    d    = m_cyc - m_last_fc;
    lt_n = m_up && m_locked && !lnk.ttc_resync && (fc ? (d % MP != 0) : (d % MP == 0));
    bad_up = m_up && !good;
    up_n = m_up;
    if (!lnk.fiber_enable) begin
      up_n = 0; m_run = 0;
    end else if (m_up) begin
      w = (m_age + 1) / WIN_LEN;
      if (w != m_win) begin m_win = w; m_win_bad = 0; end
      if (!good) m_win_bad++;
      if (m_win_bad >= BAD_CNT) up_n = 0;
      m_age++;
    end else if (good) begin
      m_run++;
      if (m_run == GOOD_CNT) begin
        up_n = 1; m_run = 0; m_age = 0; m_win = 0; m_win_bad = 0;
      end
    end else begin
      m_run = 0;
    end
    if (m_up && lnk.ttc_resync) m_locked = 0;
    else if (m_up && fc) begin m_locked = 1; m_last_fc = m_cyc; end
    if (!up_n) m_locked = 0;
    m_up = up_n;
    m_cyc++;
    if (lnk.err_cnt_clr || lnk.ttc_resync) m_err = 0;
    else begin
      m_err = m_err + int'(bad_up) + int'(lt_n);
      if (m_err > 65535) m_err = 65535;
    end
    e_kchar = lnk.rx_kchar;
    e_link  = up_n;
    e_lt    = lt_n;
    e_sync  = !lnk.fiber_enable || m_locked;
  endtask

  task automatic check_all();
    check("kchar", lnk.kchar, e_kchar);
    check("link_good", lnk.link_good, e_link);
    check("lt_trg_err", lnk.lt_trg_err, e_lt);
    check("sync_done", lnk.sync_done, e_sync);
`ifdef CFEB_LINK_MON_ERR_CNT_EN
    check("err_cnt", lnk.err_cnt, m_err);
`else
    check("err_cnt", lnk.err_cnt, 0);
`endif
  endtask

  task automatic set_in(input bit v, input logic [7:0] k, input bit ce, input bit en,
                        input bit rs, input bit clr);
    lnk.rx_kchar_valid = v;
    lnk.rx_kchar       = k;
    lnk.rx_code_err    = ce;
    lnk.fiber_enable   = en;
    lnk.ttc_resync     = rs;
    lnk.err_cnt_clr    = clr;
  endtask

  // Inputs change only at negedge; model consumes them at posedge, DUT is checked at negedge.
  task automatic cyc();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  int lt_clean, lt_early, since_fc, rs_left, dis_left;
  int perr [4] = '{0, 3, 20, 60};

  initial begin
    global_reset_n = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    model_reset();
    @(negedge clock);
    check_all();
    global_reset_n = 1'b1;

    set_in(1'b1, 8'hBC, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc();
    check("acq_link_low_7", lnk.link_good, 0);
    cyc();
    check("acq_link_up_8", lnk.link_good, 1);
    check("acq_sync_low", lnk.sync_done, 0);

    lt_clean = 0; lt_early = 0;
    for (int i = 0; i < 1700; i++) begin
      bit is_fc;
      is_fc = (i < 1340 && i % MP == 5) || i == 1386 || i == 1514 || i == 1642;
      set_in(1'b1, is_fc ? 8'hFC : 8'hBC, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      if (i == 5) check("sync_after_first_fc", lnk.sync_done, 1);
      if (i < 1340) lt_clean += int'(lnk.lt_trg_err);
      else          lt_early += int'(lnk.lt_trg_err);
    end
    check("no_lt_clean_periods", lt_clean, 0);
    check("one_lt_early_fc", lt_early, 1);

    since_fc = 0; rs_left = 0; dis_left = 0;
    for (int i = 0; i < 6000; i++) begin
      logic [7:0] k;
      bit v, ce, rs, en, clr;
      k = 8'hBC; v = 1; ce = 0;
      since_fc++;
      if (since_fc >= MP || $urandom_range(0, 299) == 0) begin
        if ($urandom_range(0, 199) != 0) begin k = 8'hFC; since_fc = 0; end
      end
      if ($urandom_range(0, 999) < perr[i / 1500]) ce = 1;
      if ($urandom_range(0, 499) == 0) v = 0;
      if ($urandom_range(0, 499) == 0) k = 8'($urandom);
      if (rs_left == 0 && $urandom_range(0, 299) == 0) rs_left = $urandom_range(1, 3);
      rs = (rs_left > 0);
      if (rs_left > 0) rs_left--;
      if (dis_left == 0 && $urandom_range(0, 1499) == 0) dis_left = $urandom_range(1, 20);
      en = (dis_left == 0);
      if (dis_left > 0) dis_left--;
      clr = ($urandom_range(0, 499) == 0);
      set_in(v, k, ce, en, rs, clr);
      cyc();
    end

    set_in(1'b1, 8'hBC, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    set_in(1'b1, 8'hBC, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc();
    #2 global_reset_n = 1'b0;
    #1;
    check("rst_kchar", lnk.kchar, 0);
    check("rst_link_good", lnk.link_good, 0);
    check("rst_lt_trg_err", lnk.lt_trg_err, 0);
    check("rst_sync_done", lnk.sync_done, 0);
    check("rst_err_cnt", lnk.err_cnt, 0);
    model_reset();
    @(negedge clock);
    global_reset_n = 1'b1;
    for (int i = 0; i < 12; i++) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
